// File: rtl/spu_exec_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : spu_exec_pipe_if
// Purpose  : Issue-side and writeback-side handshake bundle for the SPU
//            execute pipe.
// Ports    : issue side   - in_valid/in_ready, operands, immediate,
//                           destinations, alu_op, forwarding selects,
//                           wb_data, flush
//            result side  - out_valid/out_ready, out_result, out_zero,
//                           out_dest, out_jump_pc
// Modports : master = issue/writeback driver, slave = execute pipe
// Revision : 1.0  initial release
// ============================================================================
interface spu_exec_pipe_if #(
    parameter int DATA_W = 128,
    parameter int PC_W   = 11,
    parameter int REG_W  = 7
);
    logic              in_valid;
    logic              in_ready;
    logic [PC_W-1:0]   pc_plus8;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] rd_a;
    logic [DATA_W-1:0] rd_b;
    logic [REG_W-1:0]  dest_rt;
    logic [REG_W-1:0]  dest_rrr;
    logic              dest_sel;
    logic [3:0]        alu_op;
    logic [1:0]        fwd_sel_a;
    logic [1:0]        fwd_sel_b;
    logic [DATA_W-1:0] wb_data;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_result;
    logic              out_zero;
    logic [REG_W-1:0]  out_dest;
    logic [PC_W-1:0]   out_jump_pc;

    modport master (
        output in_valid, pc_plus8, imm, rd_a, rd_b, dest_rt, dest_rrr,
               dest_sel, alu_op, fwd_sel_a, fwd_sel_b, wb_data, flush,
               out_ready,
        input  in_ready, out_valid, out_result, out_zero, out_dest,
               out_jump_pc
    );

    modport slave (
        input  in_valid, pc_plus8, imm, rd_a, rd_b, dest_rt, dest_rrr,
               dest_sel, alu_op, fwd_sel_a, fwd_sel_b, wb_data, flush,
               out_ready,
        output in_ready, out_valid, out_result, out_zero, out_dest,
               out_jump_pc
    );
endinterface
`default_nettype wire

// File: rtl/spu_exec_pipe.sv
`default_nettype none
// ============================================================================
// Module   : spu_exec_pipe
// Purpose  : Pipelined SIMD execute stage. Evaluates a 32-bit-lane ALU
//            operation and a branch target in the accept cycle, then delays
//            them through LAT valid-tagged stages with a global stall.
// Ports    : clk    - clock, rising edge
//            rst_n  - asynchronous active-low reset
//            bus    - spu_exec_pipe_if.slave (issue and result handshakes)
// Params   : DATA_W (multiple of 32), PC_W, REG_W, LAT (1..8)
// Revision : 1.0  initial release
// ============================================================================
module spu_exec_pipe #(
    parameter int DATA_W = 128,
    parameter int PC_W   = 11,
    parameter int REG_W  = 7,
    parameter int LAT    = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    spu_exec_pipe_if.slave bus
);
    localparam int c_LANES = DATA_W / 32;

    logic              w_advance;
    logic              w_accept;
    logic [DATA_W-1:0] w_opa;
    logic [DATA_W-1:0] w_opb;
    logic [DATA_W-1:0] alu_d;
    logic              zero_d;
    logic [REG_W-1:0]  dest_d;
    logic [PC_W-1:0]   jpc_d;

    // Index 0 is stage 1 (loaded at accept); index LAT-1 drives the outputs.
    logic              valid_q  [LAT];
    logic [DATA_W-1:0] result_q [LAT];
    logic              zero_q   [LAT];
    logic [REG_W-1:0]  dest_q   [LAT];
    logic [PC_W-1:0]   jpc_q    [LAT];

    // Global stall: the whole pipe freezes only when the last stage holds a
    // result that writeback refuses.
    assign w_advance    = !valid_q[LAT-1] | bus.out_ready;
    assign w_accept     = bus.in_valid & w_advance;
    assign bus.in_ready = w_advance;

    // Operand selection; select 1 bypasses whatever sits on out_result now.
    always_comb begin
        w_opa = bus.rd_a;
        w_opb = bus.rd_b;
        case (bus.fwd_sel_a)
            2'd1:    w_opa = bus.out_result;
            2'd2:    w_opa = bus.wb_data;
            default: w_opa = bus.rd_a;
        endcase
        case (bus.fwd_sel_b)
            2'd1:    w_opb = bus.out_result;
            2'd2:    w_opb = bus.wb_data;
            2'd3:    w_opb = bus.imm;
            default: w_opb = bus.rd_b;
        endcase
    end

    // Lane k occupies the k-th word from the top; lane 0 is the preferred slot.
    for (genvar k = 0; k < c_LANES; k++) begin : g_lane
        localparam int c_HI = DATA_W - 1 - 32 * k;
        logic [31:0] w_a;
        logic [31:0] w_b;
        logic [31:0] w_r;

        assign w_a = w_opa[c_HI -: 32];
        assign w_b = w_opb[c_HI -: 32];

        always_comb begin
            w_r = '0;
            case (bus.alu_op)
                4'd0:    w_r = w_a + w_b;
                4'd1:    w_r = w_a - w_b;
                4'd2:    w_r = w_a & w_b;
                4'd3:    w_r = w_a | w_b;
                4'd4:    w_r = w_a ^ w_b;
                4'd5:    w_r = ~(w_a | w_b);
                4'd6:    w_r = (w_a == w_b) ? '1 : '0;
                4'd7:    w_r = ($signed(w_a) > $signed(w_b)) ? '1 : '0;
                4'd8:    w_r = w_a << w_b[4:0];
                4'd9:    w_r = w_a >> w_b[4:0];
                default: w_r = '0;
            endcase
        end

        assign alu_d[c_HI -: 32] = w_r;
    end

    assign zero_d = (alu_d[DATA_W-1 -: 32] == 32'd0);
    assign dest_d = bus.dest_sel ? bus.dest_rrr : bus.dest_rt;
    // Word offset scaled to bytes; the sum is truncated to PC_W and wraps.
    assign jpc_d  = bus.pc_plus8 + (bus.imm[PC_W-1:0] << 3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < LAT; s++) begin
                valid_q[s]  <= 1'b0;
                result_q[s] <= '0;
                zero_q[s]   <= 1'b0;
                dest_q[s]   <= '0;
                jpc_q[s]    <= '0;
            end
        end else begin
            // Delay stages, highest index first so each takes its
            // predecessor's pre-edge value.
            for (int s = LAT - 1; s > 0; s--) begin
                if (bus.flush) begin
                    valid_q[s] <= 1'b0;
                end else if (w_advance) begin
                    valid_q[s] <= valid_q[s-1];
                end
                if (w_advance) begin
                    result_q[s] <= result_q[s-1];
                    zero_q[s]   <= zero_q[s-1];
                    dest_q[s]   <= dest_q[s-1];
                    jpc_q[s]    <= jpc_q[s-1];
                end
            end
            // Stage 1: payload only moves on a real accept; a bubble just
            // clears the valid bit. Flush discards even a same-cycle accept.
            if (bus.flush) begin
                valid_q[0] <= 1'b0;
            end else if (w_advance) begin
                valid_q[0] <= w_accept;
            end
            if (w_accept) begin
                result_q[0] <= alu_d;
                zero_q[0]   <= zero_d;
                dest_q[0]   <= dest_d;
                jpc_q[0]    <= jpc_d;
            end
        end
    end

    assign bus.out_valid   = valid_q[LAT-1];
    assign bus.out_result  = result_q[LAT-1];
    assign bus.out_zero    = zero_q[LAT-1];
    assign bus.out_dest    = dest_q[LAT-1];
    assign bus.out_jump_pc = jpc_q[LAT-1];
endmodule
`default_nettype wire

// File: doc/spu_exec_pipe.md
# spu_exec_pipe

Parametrised, pipelined execute stage for the SPU datapath. It takes one decoded instruction per cycle: operands, immediate, destination register, ALU op and forwarding selects. It computes a word-lane SIMD ALU result and a branch target, then carries both through a configurable number of pipeline stages to the writeback stage. A valid/ready handshake with a global stall and a flush lets it sit between issue and writeback. It replaces the single-cycle combinational execute path.

## Interface
- DATA_W, 128: operand/result width; must be a multiple of 32.
- PC_W, 11: program counter width.
- REG_W, 7: register address width.
- LAT, 2: cycles from accept to out_valid; legal range 1–8.

- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  instruction presented
- in_ready  out  1  stage can accept this cycle
- pc_plus8  in  PC_W  PC of instruction + 8
- imm  in  DATA_W  sign-extended immediate
- rd_a, rd_b  in  DATA_W  register-file operands A, B
- dest_rt, dest_rrr  in  REG_W  candidate destination registers
- dest_sel  in  1  0 selects dest_rt, 1 selects dest_rrr
- alu_op  in  4  operation code
- fwd_sel_a, fwd_sel_b  in  2  operand source select
- wb_data  in  DATA_W  writeback bypass data
- flush  in  1  kill all in-flight instructions
- out_valid  out  1  result available
- out_ready  in  1  writeback accepts result
- out_result  out  DATA_W  ALU result
- out_zero  out  1  preferred slot of result equals 0
- out_dest  out  REG_W  destination register
- out_jump_pc  out  PC_W  branch target

## Operation
- Lane k holds bits [DATA_W-1-32k -: 32]. Lane 0, the most significant word, is the preferred slot.
- Operand select, for A and B:
  - 0 selects rd_x.
  - 1 selects the current out_result, which is forwarding from the last stage.
  - 2 selects wb_data.
  - 3 selects imm for B and rd_a for A.
- alu_op, applied per 32-bit lane:
  - 0: A+B
  - 1: A−B
  - 2: A&B
  - 3: A|B
  - 4: A^B
  - 5: ~(A|B)
  - 6: all-ones if A==B, else 0
  - 7: all-ones if A>B, signed, else 0
  - 8: A << B[4:0]
  - 9: A >> B[4:0], logical
  - 10–15: all zeros
- Carries never cross lanes. Wrap-around is modulo 2^32 per lane.
- out_zero = (lane 0 of result == 0).
- out_jump_pc = pc_plus8 + (imm[PC_W-1:0] << 3), truncated to PC_W; wraps silently.
- out_dest = dest_sel ? dest_rrr : dest_rt, captured at accept.
- The ALU is evaluated in the accept cycle and registered into stage 1. Stages 2..LAT are pure delay registers, each carrying a valid bit.

## Timing
- advance = !out_valid | out_ready. in_ready = advance, a combinational global stall.
- Accept happens when in_valid & in_ready.
- When advance is high, all stages shift by one. Stage 1 loads the accepted instruction, or an empty slot if nothing is accepted.
- When advance is low, every stage holds, including its payload. out_* stay stable while out_valid & !out_ready.
- Unstalled latency is exactly LAT cycles: accepted in cycle n gives out_valid in cycle n+LAT. Throughput is 1 per cycle.
- Bubbles are not squeezed out. The stall is global and bubbles travel with the pipe.
- flush, synchronous: clears every valid bit at the next edge. An instruction accepted in the flush cycle is discarded. Payload registers may keep stale data. flush wins over stall.
- Forward select 1 uses out_result as it stands in the accept cycle, whether or not out_valid is set.
- Reset, asserted at any time including mid-stall: all valid bits go to 0 and out_result, out_zero, out_dest and out_jump_pc go to 0 immediately. in_ready = 1 out of reset.

## Test plan
- LAT=2, add with A lanes 0x00000001 and B lanes 0xFFFFFFFF -> out_valid 2 cycles later; result all-zero lanes, out_zero=1, no carry into neighbouring lanes.
- 5 back-to-back accepts, then out_ready held low for 3 cycles -> in_ready=0 for those cycles; out_result held stable; all 5 results appear in order with none lost or duplicated.
- pc_plus8=0x7F8, imm=0x001 -> out_jump_pc=0x000 (wrap); imm=0x7FF (−1) with pc_plus8=0x010 -> 0x008.
- fwd_sel_a=1 while out_result=0x…05 in lane 0, rd_b=3, op 1 -> lane 0 result 2; fwd_sel_b=2 uses wb_data; fwd_sel_b=3 uses imm.
- 3 instructions in flight, flush pulsed together with a new accept -> no out_valid for the next LAT cycles; next accept emerges normally.
- rst_n dropped asynchronously mid-stall with LAT=4 -> all outputs 0 and out_valid=0 before the next clock edge; in_ready=1 after release.
